// File: rtl/eth_stream_pkg.sv
// Shared constants and encodings for the Ethernet TX stream blocks.
// Holds the default stream widths and the TX arbiter state/source encodings.
package eth_stream_pkg;

  localparam int unsigned ETH_DATA_W = 64;
  localparam int unsigned ETH_USER_W = 80;
  localparam int unsigned ETH_KEEP_W = ETH_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_ARP = 2'd1,
    ST_GNT_IP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_ARP = 1'b0,
    SRC_IP  = 1'b1
  } arb_src_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice: one cycle of latency, full throughput.
// The payload is opaque; callers pack whatever sideband they need into it.
module axis_reg_slice #(
  parameter int unsigned P_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [P_W-1:0] s_payload,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [P_W-1:0] m_payload,
  output logic           m_valid,
  input  logic           m_ready
);

  // Accept a new beat whenever the stage is empty or is draining this cycle.
  assign s_ready = !m_valid || m_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_valid   <= 1'b0;
      // NOTE: the payload register is reset as well, so the downstream
      // interface shows all-zero outputs after reset, not stale data.
      m_payload <= '0;
    end else if (s_valid && s_ready) begin
      m_valid   <= 1'b1;
      m_payload <= s_payload;
    end else if (m_ready) begin
      m_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic 2:1 AXI-Stream arbiter merging the ARP and IP/UDP TX streams onto the MAC.
// Define MAC_TX_ARB_ARP_PRIO_EN for fixed ARP priority; default build is round-robin.
module mac_tx_arbiter
  import eth_stream_pkg::*;
#(
  parameter int unsigned P_DATA_W = ETH_DATA_W,
  parameter int unsigned P_USER_W = ETH_USER_W,
  parameter int unsigned P_KEEP_W = P_DATA_W / 8
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic [P_DATA_W-1:0] s_axis_arp_data,
  input  logic [P_USER_W-1:0] s_axis_arp_user,
  input  logic [P_KEEP_W-1:0] s_axis_arp_keep,
  input  logic                s_axis_arp_last,
  input  logic                s_axis_arp_valid,
  output logic                s_axis_arp_ready,

  input  logic [P_DATA_W-1:0] s_axis_ip_data,
  input  logic [P_USER_W-1:0] s_axis_ip_user,
  input  logic [P_KEEP_W-1:0] s_axis_ip_keep,
  input  logic                s_axis_ip_last,
  input  logic                s_axis_ip_valid,
  output logic                s_axis_ip_ready,

  output logic [P_DATA_W-1:0] m_axis_mac_data,
  output logic [P_USER_W-1:0] m_axis_mac_user,
  output logic [P_KEEP_W-1:0] m_axis_mac_keep,
  output logic                m_axis_mac_last,
  output logic                m_axis_mac_valid,
  input  logic                m_axis_mac_ready,

  output logic                o_arb_busy
);

  localparam int unsigned LP_BEAT_W = P_DATA_W + P_USER_W + P_KEEP_W + 1;

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic                 tie_to_arp;
  logic                 slice_s_valid;
  logic                 slice_s_ready;
  logic [LP_BEAT_W-1:0] slice_s_payload;
  logic [LP_BEAT_W-1:0] slice_m_payload;
  logic [LP_BEAT_W-1:0] arp_beat;
  logic [LP_BEAT_W-1:0] ip_beat;

  assign arp_beat = {s_axis_arp_last, s_axis_arp_keep, s_axis_arp_user, s_axis_arp_data};
  assign ip_beat  = {s_axis_ip_last,  s_axis_ip_keep,  s_axis_ip_user,  s_axis_ip_data};

`ifdef MAC_TX_ARB_ARP_PRIO_EN
  // ARP replies are small and latency-critical; they always win a tie.
  assign tie_to_arp = 1'b1;
`else
  arb_src_t last_winner_q;

  // Only contested grants move the pointer; an uncontested grant leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_winner_q <= SRC_IP;
    end else if (state_q == ST_IDLE && s_axis_arp_valid && s_axis_ip_valid) begin
      last_winner_q <= (last_winner_q == SRC_IP) ? SRC_ARP : SRC_IP;
    end
  end

  assign tie_to_arp = (last_winner_q == SRC_IP);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d          = state_q;
    slice_s_valid    = 1'b0;
    slice_s_payload  = ip_beat;
    s_axis_arp_ready = 1'b0;
    s_axis_ip_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_axis_arp_valid && s_axis_ip_valid) begin
          state_d = tie_to_arp ? ST_GNT_ARP : ST_GNT_IP;
        end else if (s_axis_arp_valid) begin
          state_d = ST_GNT_ARP;
        end else if (s_axis_ip_valid) begin
          state_d = ST_GNT_IP;
        end
      end

      ST_GNT_ARP: begin
        slice_s_valid    = s_axis_arp_valid;
        slice_s_payload  = arp_beat;
        s_axis_arp_ready = slice_s_ready;
        // The grant is held through any valid gap until the last beat is taken.
        if (s_axis_arp_valid && slice_s_ready && s_axis_arp_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_GNT_IP: begin
        slice_s_valid   = s_axis_ip_valid;
        slice_s_payload = ip_beat;
        s_axis_ip_ready = slice_s_ready;
        if (s_axis_ip_valid && slice_s_ready && s_axis_ip_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  axis_reg_slice #(
    .P_W (LP_BEAT_W)
  ) u_out_slice (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .s_payload (slice_s_payload),
    .s_valid   (slice_s_valid),
    .s_ready   (slice_s_ready),
    .m_payload (slice_m_payload),
    .m_valid   (m_axis_mac_valid),
    .m_ready   (m_axis_mac_ready)
  );

  assign {m_axis_mac_last, m_axis_mac_keep, m_axis_mac_user, m_axis_mac_data} = slice_m_payload;

  assign o_arb_busy = (state_q != ST_IDLE);

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Frame-atomic 2:1 AXI-Stream arbiter sitting directly downstream of the ARP block's TX stream (m_axis_arp_*) and the IP/UDP TX stream.
- Merges both onto a single stream feeding the 10G MAC TX path.
- Once granted, a frame runs from its first beat through its `last` beat without interleaving.
- Output is a registered slice: 1-cycle data latency, full throughput within a frame.

Parameters:
P_DATA_W, 64, stream data width in bits
P_USER_W, 80, sideband user width in bits; passed through per beat unmodified
P_KEEP_W, P_DATA_W/8, byte-enable width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
s_axis_arp_data  in  P_DATA_W  ARP frame data
s_axis_arp_user  in  P_USER_W  ARP sideband
s_axis_arp_keep  in  P_KEEP_W  ARP byte enables
s_axis_arp_last  in  1  ARP end of frame
s_axis_arp_valid  in  1  ARP beat valid
s_axis_arp_ready  out  1  ARP beat accepted
s_axis_ip_data  in  P_DATA_W  IP frame data
s_axis_ip_user  in  P_USER_W  IP sideband
s_axis_ip_keep  in  P_KEEP_W  IP byte enables
s_axis_ip_last  in  1  IP end of frame
s_axis_ip_valid  in  1  IP beat valid
s_axis_ip_ready  out  1  IP beat accepted
m_axis_mac_data  out  P_DATA_W  merged data
m_axis_mac_user  out  P_USER_W  merged sideband
m_axis_mac_keep  out  P_KEEP_W  merged byte enables
m_axis_mac_last  out  1  merged end of frame
m_axis_mac_valid  out  1  merged beat valid
m_axis_mac_ready  in  1  MAC accepts beat
o_arb_busy  out  1  high while state is not IDLE

Behaviour:
- Clock and reset: single clock i_clk; i_rst is asynchronous and active-high.
- Reset values:
  - all m_axis_mac_* = 0; s_axis_*_ready = 0; o_arb_busy = 0.
  - state = IDLE; last-winner = IP, so ARP wins the first tie.
- States: IDLE, GNT_ARP, GNT_IP.
- IDLE:
  - If exactly one s_valid is high, go to that grant state.
  - If both are high, grant the source that did not win last time (round-robin), then update last-winner.
  - Arbitration costs one cycle. No s_ready is asserted in IDLE.
- GNT_x:
  - s_axis_x_ready = !m_axis_mac_valid || m_axis_mac_ready. The other source's ready = 0.
  - On an s handshake, the beat (data/user/keep/last) is registered into the output slice and m_axis_mac_valid = 1 on the next cycle.
  - On an m handshake with no new beat loaded, m_axis_mac_valid is cleared.
  - When the accepted s beat has last = 1: go to IDLE on the next cycle; ready drops. The output slice still drains normally.
- Output hold: while m_axis_mac_valid = 1 and m_axis_mac_ready = 0, all m_axis_mac_* are held stable.
- Frame gap: minimum 1 idle cycle on the input side between consecutive frames. Output bubbles arise only from that gap or from MAC backpressure.
- Source deasserts valid mid-frame: the grant is held indefinitely and no switch occurs. A frame is never truncated by the arbiter.
- Single-beat frame (valid and last on the same beat): legal; state returns to IDLE after one transfer.
- Keep and user are never inspected or altered.
- Reset asserted mid-frame: the output is dropped immediately (valid = 0). The upstream block is responsible for its own restart.

Optional Feature:
- Macro: MAC_TX_ARB_ARP_PRIO_EN.
- Defined: fixed priority. In IDLE with both valid, ARP always wins, so ARP replies are never starved behind bulk IP traffic. The last-winner register is not implemented.
- Undefined: round-robin as described above.

Decomposition:
- Shared package (eth_stream_pkg): the width constants 64/80/8, and the state encoding localparams ST_IDLE/ST_GNT_ARP/ST_GNT_IP.
- One natural sub-module: axis_reg_slice, the single-stage output register with the ready = !valid || ready_out rule. It is reusable on other TX paths.

Test Plan:
- ARP-only frame: 6 beats, last keep = 8'h0F, m_ready = 1 → 6 output beats, first output 2 cycles after the first s_valid; last beat keep = 8'h0F; data and user bit-exact.
- Simultaneous arrival: ARP frame of 6 beats and IP frame of 10 beats, both valid at cycle 0 after reset → ARP frame out first, then the IP frame. Repeating the same pair → IP first (round-robin). With the macro defined → ARP first both times.
- Backpressure: IP frame of 8 beats, m_ready toggled 1,0,1,0 → no beat lost or duplicated; m_* stable whenever valid = 1 and ready = 0; s_axis_ip_ready low in the cycles where the slice is full and m_ready = 0.
- Mid-frame stall: IP s_valid drops for 5 cycles at beat 3 while ARP is valid → no ARP beat emitted until IP last is transferred; ARP frame follows after a 1-cycle gap.
- Single-beat frames: back-to-back 1-beat ARP frames with last = 1 → each output with last = 1; o_arb_busy pulses once per frame.
- Reset mid-frame: i_rst asserted asynchronously at beat 4 of 8 → m_axis_mac_valid = 0 and both s_ready = 0 in the same cycle; a fresh frame after reset release transfers correctly.
